// File: rtl/ex_mem_pkg.sv
// rtl/ex_mem_pkg.sv - shared constants and payload sizing for the EX->MEM skid stage
package ex_mem_pkg;

  localparam int CTRL_W        = 5;
  localparam int CTRL_MUX_2    = 0;
  localparam int CTRL_MUX_3    = 1;
  localparam int CTRL_MEM_RD   = 2;
  localparam int CTRL_MEM_WR   = 3;
  localparam int CTRL_BANCO_WR = 4;

  function automatic int lane_w(input int data_w, input int reg_w);
    return 2 * data_w + 2 * reg_w + CTRL_W;
  endfunction

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// rtl/ex_mem_skid_stage_if.sv - EX-side and MEM-side bundle handshake of the skid stage
interface ex_mem_skid_stage_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  import ex_mem_pkg::*;

  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES-1:0]          lane_vld_i;
  logic [LANES*DATA_W-1:0]   alu_i;
  logic [LANES*REG_W-1:0]    rd_i;
  logic [LANES*REG_W-1:0]    rt_i;
  logic [LANES*DATA_W-1:0]   dato_b_i;
  logic [LANES*CTRL_W-1:0]   ctrl_i;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES-1:0]          lane_vld_o;
  logic [LANES*DATA_W-1:0]   alu_o;
  logic [LANES*REG_W-1:0]    rd_o;
  logic [LANES*REG_W-1:0]    rt_o;
  logic [LANES*DATA_W-1:0]   dato_b_o;
  logic [LANES*CTRL_W-1:0]   ctrl_o;
  logic [1:0]                occupancy;

  modport master (
    output flush, in_valid, lane_vld_i, alu_i, rd_i, rt_i, dato_b_i, ctrl_i, out_ready,
    input  in_ready, out_valid, lane_vld_o, alu_o, rd_o, rt_o, dato_b_o, ctrl_o, occupancy
  );

  modport slave (
    input  flush, in_valid, lane_vld_i, alu_i, rd_i, rt_i, dato_b_i, ctrl_i, out_ready,
    output in_ready, out_valid, lane_vld_o, alu_o, rd_o, rt_o, dato_b_o, ctrl_o, occupancy
  );

endinterface

// File: rtl/ex_mem_skid_entry.sv
// rtl/ex_mem_skid_entry.sv - one bundle slot: valid bit, lane mask and packed payload
module ex_mem_skid_entry #(
  parameter int LANES = 2,
  parameter int PW    = 148
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             d_valid,
  input  logic [LANES-1:0] d_mask,
  input  logic [PW-1:0]    d_payload,
  output logic             valid,
  output logic [LANES-1:0] mask,
  output logic [PW-1:0]    payload
);

  // An emptying load leaves mask/payload untouched so idle entries do not toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      mask    <= '0;
      payload <= '0;
    end else if (load) begin
      valid <= d_valid;
      if (d_valid) begin
        mask    <= d_mask;
        payload <= d_payload;
      end
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - two-entry EX->MEM skid stage with flush and per-lane kill gating
module ex_mem_skid_stage
  import ex_mem_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic               clk,
  input logic               rst,
  ex_mem_skid_stage_if.slave bus
);

  localparam int PW    = LANES * lane_w(DATA_W, REG_W);
  localparam int RD_LO = LANES * DATA_W;
  localparam int RT_LO = RD_LO + LANES * REG_W;
  localparam int DB_LO = RT_LO + LANES * REG_W;
  localparam int CT_LO = DB_LO + LANES * DATA_W;

  logic             main_v, skid_v;
  logic [LANES-1:0] main_mask, skid_mask;
  logic [PW-1:0]    main_payload, skid_payload, in_payload;
  logic             main_load, main_dv, main_from_skid;
  logic             skid_load, skid_dv, skid_v_nxt;
  logic             ready_q, accept, drain;
  logic [LANES*CTRL_W-1:0] ctrl_gated;

  assign in_payload = {bus.ctrl_i, bus.dato_b_i, bus.rt_i, bus.rd_i, bus.alu_i};
  assign accept     = bus.in_valid & ready_q;
  assign drain      = main_v & bus.out_ready;

  always_comb begin
    main_load      = 1'b0;
    main_dv        = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_dv        = 1'b0;
    if (bus.flush) begin
      main_load = 1'b1;
      skid_load = 1'b1;
    end else if (!main_v || drain) begin
      main_load = 1'b1;
      if (skid_v) begin
        main_from_skid = 1'b1;
        main_dv        = 1'b1;
        skid_load      = 1'b1;
        skid_dv        = accept;
      end else begin
        main_dv = accept;
      end
    end else if (accept) begin
      skid_load = 1'b1;
      skid_dv   = 1'b1;
    end
  end

  assign skid_v_nxt = skid_load ? skid_dv : skid_v;

  ex_mem_skid_entry #(.LANES(LANES), .PW(PW)) main_q (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .d_valid   (main_dv),
    .d_mask    (main_from_skid ? skid_mask : bus.lane_vld_i),
    .d_payload (main_from_skid ? skid_payload : in_payload),
    .valid     (main_v),
    .mask      (main_mask),
    .payload   (main_payload)
  );

  ex_mem_skid_entry #(.LANES(LANES), .PW(PW)) skid_q (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .d_valid   (skid_dv),
    .d_mask    (bus.lane_vld_i),
    .d_payload (in_payload),
    .valid     (skid_v),
    .mask      (skid_mask),
    .payload   (skid_payload)
  );

  // Ready is a flop of the next SKID state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= ~skid_v_nxt;
  end

  always_comb begin
    ctrl_gated = '0;
    for (int k = 0; k < LANES; k++) begin
      ctrl_gated[k*CTRL_W +: CTRL_W] = main_payload[CT_LO + k*CTRL_W +: CTRL_W] & {CTRL_W{main_v}};
      ctrl_gated[k*CTRL_W + CTRL_MEM_WR]   = ctrl_gated[k*CTRL_W + CTRL_MEM_WR]   & main_mask[k];
      ctrl_gated[k*CTRL_W + CTRL_BANCO_WR] = ctrl_gated[k*CTRL_W + CTRL_BANCO_WR] & main_mask[k];
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.out_valid  = main_v;
  assign bus.lane_vld_o = main_mask;
  assign bus.alu_o      = main_payload[0     +: LANES*DATA_W];
  assign bus.rd_o       = main_payload[RD_LO +: LANES*REG_W];
  assign bus.rt_o       = main_payload[RT_LO +: LANES*REG_W];
  assign bus.dato_b_o   = main_payload[DB_LO +: LANES*DATA_W];
  assign bus.ctrl_o     = ctrl_gated;
  assign bus.occupancy  = {1'b0, main_v} + {1'b0, skid_v};

endmodule
